// File: rtl/bht_gshare_pht.sv
// Gshare PHT: 2-bit saturating counters indexed by pc[IDX_W+1:2] ^ GHR, with speculative GHR and mispredict recovery.
// Latency: lookup response 1 cycle after acceptance; resolve updates are a 2-stage read-modify-write (write lands end of T+1).
// Backpressure: pred_ready low only during the post-reset init sweep (2**IDX_W cycles); in RUN one lookup/update per cycle, no stall.
//
// Ports: clk/rst (sync, active-high); pred_valid/pred_pc/pred_ready fetch lookup;
//        rsp_valid/rsp_taken/rsp_idx/rsp_ghr registered response; upd_* resolve-side update
//        and recovery; ghr_out exposes the current global history.
module bht_gshare_pht #(
    parameter int          PC_W     = 32,
    parameter int          IDX_W    = 6,
    parameter int          GHR_W    = 6,
    parameter logic [1:0]  INIT_STT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pred_ready,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             rsp_valid,
    output logic             rsp_taken,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [GHR_W-1:0] rsp_ghr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_mispred,
    input  logic [GHR_W-1:0] upd_ghr,
    output logic [GHR_W-1:0] ghr_out
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [1:0]       pht [DEPTH];
    logic [GHR_W-1:0] ghr_q;

    // U2 stage registers: index, resolved direction and counter state read in U1
    logic             u2_vld;
    logic [IDX_W-1:0] u2_idx;
    logic             u2_taken;
    logic [1:0]       u2_stt;
    logic [1:0]       u2_next;

    logic             running;
    logic             lkp_fire;
    logic             upd_fire;
    logic             recover;
    logic [IDX_W-1:0] pred_idx;
    logic [1:0]       pred_stt;
    logic [1:0]       upd_stt;
    logic             unused_bits;

    assign running    = (state_q == ST_RUN);
    assign pred_ready = running & ~rst;
    assign lkp_fire   = pred_valid & running;
    assign upd_fire   = upd_valid & running;
    assign recover    = upd_fire & upd_mispred;
    assign ghr_out    = ghr_q;

    assign pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);

    assign unused_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0], upd_ghr[GHR_W-1]};

    // Saturating counter step for the write committing this cycle
    always_comb begin
        u2_next = u2_stt;
        if (u2_taken) begin
            if (u2_stt != 2'b11) u2_next = u2_stt + 2'b01;
        end else begin
            if (u2_stt != 2'b00) u2_next = u2_stt - 2'b01;
        end
    end

    // Both read ports see the U2 write that commits this cycle; a same-cycle U1
    // update to the lookup index is not visible until its own U2 cycle.
    assign pred_stt = (u2_vld && (u2_idx == pred_idx)) ? u2_next : pht[pred_idx];
    assign upd_stt  = (u2_vld && (u2_idx == upd_idx))  ? u2_next : pht[upd_idx];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            ghr_q     <= '0;
            u2_vld    <= 1'b0;
            u2_idx    <= '0;
            u2_taken  <= 1'b0;
            u2_stt    <= '0;
            rsp_valid <= 1'b0;
            rsp_taken <= 1'b0;
            rsp_idx   <= '0;
            rsp_ghr   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            u2_vld    <= upd_fire;
            u2_idx    <= upd_idx;
            u2_taken  <= upd_taken;
            u2_stt    <= upd_stt;
            rsp_valid <= lkp_fire;
            if (lkp_fire) begin
                rsp_taken <= pred_stt[1];
                rsp_idx   <= pred_idx;
                rsp_ghr   <= ghr_q;
            end
            // Recovery wins over the speculative shift of a same-cycle lookup
            if (recover) begin
                ghr_q <= {upd_ghr[GHR_W-2:0], upd_taken};
            end else if (lkp_fire) begin
                ghr_q <= {ghr_q[GHR_W-2:0], pred_stt[1]};
            end
        end
    end

    // Table storage: init sweep and U2 writes are mutually exclusive by FSM state;
    // a U2 write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                pht[ptr_q] <= INIT_STT;
            end else if (u2_vld) begin
                pht[u2_idx] <= u2_next;
            end
        end
    end

endmodule

// File: tb/tb_bht_gshare_pht.sv
// Bench for bht_gshare_pht: directed lookups/updates, scoreboard queue of expected responses.
// Latency: expectations are pushed at issue; the monitor pops on every rsp_valid.
// Backpressure: lookups are only issued once pred_ready is high.
module tb_bht_gshare_pht;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        rsp_valid;
    logic        rsp_taken;
    logic [5:0]  rsp_idx;
    logic [5:0]  rsp_ghr;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispred;
    logic [5:0]  upd_ghr;
    logic [5:0]  ghr_out;

    always #5 clk = ~clk;

    bht_gshare_pht #(.PC_W(32), .IDX_W(6), .GHR_W(6), .INIT_STT(2'b01)) dut (
        .clk         (clk),
        .rst         (rst),
        .pred_ready  (pred_ready),
        .pred_valid  (pred_valid),
        .pred_pc     (pred_pc),
        .rsp_valid   (rsp_valid),
        .rsp_taken   (rsp_taken),
        .rsp_idx     (rsp_idx),
        .rsp_ghr     (rsp_ghr),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_taken   (upd_taken),
        .upd_mispred (upd_mispred),
        .upd_ghr     (upd_ghr),
        .ghr_out     (ghr_out)
    );

    typedef struct packed {
        logic       taken;
        logic [5:0] idx;
        logic [5:0] ghr;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Bench-side history used to steer lookups onto the wanted table index
    logic [5:0] ghr_m;
    logic       lkp_pend;
    logic       lkp_taken;
    logic       mis_pend;
    logic [5:0] mis_ghr_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lookup(input int idx, input logic exp_taken);
        logic [23:0] hi;
        logic [1:0]  lo;
        hi = 24'($urandom);
        lo = 2'($urandom);
        pred_valid = 1'b1;
        pred_pc    = {hi, 6'(idx) ^ ghr_m, lo};
        exp_q.push_back(rsp_t'{exp_taken, 6'(idx), ghr_m});
        lkp_pend   = 1'b1;
        lkp_taken  = exp_taken;
    endtask

    task automatic update(input int idx, input logic taken, input logic mis, input logic [5:0] g);
        upd_valid   = 1'b1;
        upd_idx     = 6'(idx);
        upd_taken   = taken;
        upd_mispred = mis;
        upd_ghr     = g;
        if (mis) begin
            mis_pend  = 1'b1;
            mis_ghr_n = {g[4:0], taken};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mis_pend)      ghr_m = mis_ghr_n;
        else if (lkp_pend) ghr_m = {ghr_m[4:0], lkp_taken};
        lkp_pend    = 1'b0;
        mis_pend    = 1'b0;
        pred_valid  = 1'b0;
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold reset two cycles, check outputs, then measure the init sweep length.
    // A lookup offered on the first INIT cycle must be ignored.
    task automatic reset_and_sweep();
        int n;
        rst = 1'b1;
        idle(2);
        check("rst_pred_ready", 32'(pred_ready), 0);
        check("rst_rsp_valid",  32'(rsp_valid),  0);
        check("rst_rsp_taken",  32'(rsp_taken),  0);
        check("rst_rsp_idx",    32'(rsp_idx),    0);
        check("rst_ghr_out",    32'(ghr_out),    0);
        rst   = 1'b0;
        ghr_m = '0;
        n     = 0;
        pred_valid = 1'b1;
        pred_pc    = 32'h0000_0014;
        do begin
            tick();
            n++;
            if (n == 1) check("init_lookup_ignored", 32'(rsp_valid), 0);
        end while (!pred_ready && n < 200);
        check("init_sweep_cycles", 32'(n), 64);
    endtask

    // Scoreboard monitor, sampling away from the active edge
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rsp_unexpected: got idx=%0d ghr=0x%0h, expected no response at %0t",
                         rsp_idx, rsp_ghr, $time);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_taken_idx_ghr", 32'({rsp_taken, rsp_idx, rsp_ghr}), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispred = 1'b0; upd_ghr = '0;
        ghr_m = '0; lkp_pend = 1'b0; lkp_taken = 1'b0; mis_pend = 1'b0; mis_ghr_n = '0;

        reset_and_sweep();

        // Freshly initialised entries predict not-taken
        lookup(3, 1'b0);  tick();
        lookup(17, 1'b0); tick();
        idle(1);

        // Saturation up: 01 -> 10 -> 11 -> 11
        for (int i = 0; i < 3; i++) begin update(5, 1'b1, 1'b0, 6'd0); tick(); end
        idle(2);
        lookup(5, 1'b1); tick();
        check("ghr_after_taken_pred", 32'(ghr_out), 32'h01);

        // Saturation down: 11 -> 10 -> 01 -> 00 -> 00
        for (int i = 0; i < 4; i++) begin update(5, 1'b0, 1'b0, 6'd0); tick(); end
        idle(2);
        lookup(5, 1'b0); tick();

        // Back-to-back same index: 01 -> 11, then one not-taken -> 10 (still taken)
        update(9, 1'b1, 1'b0, 6'd0); tick();
        update(9, 1'b1, 1'b0, 6'd0); tick();
        update(9, 1'b0, 1'b0, 6'd0); tick();
        idle(2);
        lookup(9, 1'b1); tick();

        // Independent indices in consecutive cycles
        update(20, 1'b1, 1'b0, 6'd0); tick();
        update(21, 1'b1, 1'b0, 6'd0); tick();
        idle(2);
        lookup(20, 1'b1); tick();
        lookup(21, 1'b1); tick();

        // Recovery to zero, two taken predictions, recovery again
        update(40, 1'b0, 1'b1, 6'd0); tick();
        check("recover_to_zero", 32'(ghr_out), 32'h00);
        lookup(9, 1'b1);  tick();
        lookup(20, 1'b1); tick();
        check("spec_ghr_two_taken", 32'(ghr_out), 32'h03);
        update(41, 1'b0, 1'b1, 6'd0); tick();
        check("recover_after_spec", 32'(ghr_out), 32'h00);

        // Recovery and lookup in the same cycle: lookup shift is dropped
        lookup(9, 1'b1);
        update(42, 1'b1, 1'b1, 6'b000101);
        tick();
        check("collision_ghr", 32'(ghr_out), 32'h0B);
        check("collision_rsp_valid", 32'(rsp_valid), 1);

        // Idx 42 U2 writes 10 this cycle; same-cycle NT update must not be seen by the lookup
        update(42, 1'b0, 1'b0, 6'd0);
        lookup(42, 1'b1);
        tick();
        // Now the NT write (01) commits this cycle and is bypassed to the lookup
        lookup(42, 1'b0); tick();
        check("ghr_after_mixed", 32'(ghr_out), 32'h2E);
        idle(2);

        // Reset while an update is in U2: write dropped, full sweep again
        update(50, 1'b1, 1'b0, 6'd0); tick();
        reset_and_sweep();
        lookup(9, 1'b0);  tick();
        lookup(50, 1'b0); tick();
        check("ghr_after_reinit", 32'(ghr_out), 32'h00);
        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
